// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring phase checker.
package ring_pkg;

  localparam int unsigned MAX_N = 64;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Rotate the low n bits of v left by one (bit n-1 wraps to bit 0).
  function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] v, input int unsigned n);
    logic [MAX_N-1:0] mask;
    mask = (MAX_N'(1) << n) - MAX_N'(1);
    return ((v << 1) | ((v & mask) >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational one-hot detector and binary encoder for an N-bit ring vector.
module ring_onehot_check
  import ring_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]  phase,
  output logic          is_onehot_c,
  output logic [PW-1:0] pos_c
);

  localparam int unsigned CW = clog2(N + 1);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt   = '0;
    pos_c = '0;
    for (int i = 0; i < N; i++) begin
      if (phase[i]) begin
        cnt   = cnt + CW'(1);
        pos_c = PW'(i);
      end
    end
    is_onehot_c = (cnt == CW'(1));
  end

endmodule

// File: rtl/ring_phase_checker.sv
// Tracks a one-hot ring counter: checks each step, locks, counts revolutions and faults.
module ring_phase_checker
  import ring_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned REV_W    = 16,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_CNT = 2,
  localparam int unsigned PW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [N-1:0]     PHASE,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             ERR,
  output logic             ERR_PULSE,
  output logic [PW-1:0]    POS,
  output logic [REV_W-1:0] REV,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int unsigned GCW = (clog2(LOCK_CNT) > 0) ? clog2(LOCK_CNT) : 1;

  state_t         state;
  logic [N-1:0]   phase_q;
  logic           ce_q;
  logic [N-1:0]   phase_p;
  logic           prev_valid;
  logic [GCW-1:0] good_cnt;

  logic             is_onehot_c;
  logic [PW-1:0]    pos_c;
  logic [N-1:0]     expected_c;
  logic             good_step_c;
  logic             wrap_c;
  logic             fault_c;
  logic [REV_W-1:0] rev_base_c;
  logic [REV_W-1:0] rev_next_c;
  logic [ERR_W-1:0] cnt_base_c;
  logic [ERR_W-1:0] err_cnt_next_c;
  logic             err_next_c;

  ring_onehot_check #(.N(N)) u_onehot (
    .phase       (phase_q),
    .is_onehot_c (is_onehot_c),
    .pos_c       (pos_c)
  );

  // Step qualification and counter next values; a clear is applied before same-cycle events.
  always_comb begin
    expected_c     = ce_q ? N'(rotl(MAX_N'(phase_p), N)) : phase_p;
    good_step_c    = is_onehot_c && prev_valid && (phase_q == expected_c);
    wrap_c         = good_step_c && ce_q && phase_p[N-1];
    fault_c        = (state == ST_LOCKED) && !good_step_c;
    rev_base_c     = CLR ? '0 : REV;
    rev_next_c     = ((state == ST_LOCKED) && wrap_c) ? rev_base_c + REV_W'(1) : rev_base_c;
    cnt_base_c     = CLR ? '0 : ERR_CNT;
    err_cnt_next_c = (fault_c && (cnt_base_c != '1)) ? cnt_base_c + ERR_W'(1) : cnt_base_c;
    err_next_c     = fault_c || (ERR && !CLR);
  end

  // Sample pipeline, lock FSM and registered status outputs.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_SYNC;
      phase_q    <= '0;
      ce_q       <= 1'b0;
      phase_p    <= '0;
      prev_valid <= 1'b0;
      good_cnt   <= '0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
      ERR_PULSE  <= 1'b0;
      POS        <= '0;
      REV        <= '0;
      ERR_CNT    <= '0;
    end else begin
      phase_q    <= PHASE;
      ce_q       <= CE;
      phase_p    <= phase_q;
      prev_valid <= is_onehot_c;
      if (is_onehot_c) POS <= pos_c;
      ERR_PULSE  <= fault_c;
      ERR        <= err_next_c;
      ERR_CNT    <= err_cnt_next_c;
      REV        <= rev_next_c;

      case (state)
        ST_SYNC: begin
          LOCKED <= 1'b0;
          if (!good_step_c) begin
            good_cnt <= '0;
          end else if (good_cnt == GCW'(LOCK_CNT - 1)) begin
            good_cnt <= '0;
            state    <= ST_LOCKED;
            LOCKED   <= 1'b1;
          end else begin
            good_cnt <= good_cnt + GCW'(1);
          end
        end
        ST_LOCKED: begin
          if (!good_step_c) begin
            state  <= ST_FAULT;
            LOCKED <= 1'b0;
          end else begin
            LOCKED <= 1'b1;
          end
        end
        ST_FAULT: begin
          state    <= ST_SYNC;
          LOCKED   <= 1'b0;
          good_cnt <= '0;
        end
        default: begin
          state    <= ST_SYNC;
          LOCKED   <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule
